message_process: RTL and testbench

Serial message transmitter: captures a parallel message word on a `send` request and shifts it out on a single-wire `data` line as a framed, UART-style bit stream. It sits between a local controller and a one-bit link. Each frame is idle-high, a low start bit, the message LSB first, an optional parity bit and a high stop bit. A parameterised divider paces the bits.

---
 rtl/message_process_pkg.sv | 19 +
 rtl/message_process_if.sv | 26 ++
 rtl/message_process_bit_tick_gen.sv | 32 +++
 rtl/message_process.sv | 125 ++++++++++++
 tb/tb_message_process.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/message_process_pkg.sv
// message_process shared types and line levels.
// Parity build option: MESSAGE_PROCESS_PARITY_EN.
package message_process_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  localparam int DIV_W = 16;

endpackage

// File: rtl/message_process_if.sv
// message_process request / serial line bundle.
// Controller drives send/message, transmitter drives data/busy.
interface message_process_if #(
  parameter int MSG_W = 5
) ();

  logic             send;
  logic [MSG_W-1:0] message;
  logic             data;
  logic             busy;

  modport master (
    output send,
    output message,
    input  data,
    input  busy
  );

  modport slave (
    input  send,
    input  message,
    output data,
    output busy
  );

endinterface

// File: rtl/message_process_bit_tick_gen.sv
// Bit-period divider: counts 0..CLK_DIV-1, one-cycle tick at terminal.
// Synchronous clear holds the count at zero.
module bit_tick_gen
  import message_process_pkg::*;
#(
  parameter int CLK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  // next count: clear, wrap on terminal, else increment
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  // divider register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/message_process.sv
// Framed serial transmitter: start, MSG_W data bits LSB first, stop.
// Define MESSAGE_PROCESS_PARITY_EN to add an even parity bit.
module message_process
  import message_process_pkg::*;
#(
  parameter int MSG_W   = 5,
  parameter int CLK_DIV = 100
) (
  input logic             clk,
  input logic             rst,
  message_process_if.slave bus
);

  localparam int CNT_W = $clog2(MSG_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(MSG_W - 1);

  state_e           state_q, state_d;
  logic [MSG_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             send_q;
  logic             armed_q;
  logic             data_q, data_d;
  logic             busy_q, busy_d;
  logic             req;
  logic             tick;
`ifdef MESSAGE_PROCESS_PARITY_EN
  logic             par_q, par_d;
`endif

  // armed_q blocks a send already high when reset releases
  assign req = bus.send & ~send_q & armed_q;

  bit_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == IDLE),
    .tick (tick)
  );

  // frame sequencing, shift register and bit counter
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
`ifdef MESSAGE_PROCESS_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: if (req) begin
        state_d = START;
        shift_d = bus.message;
`ifdef MESSAGE_PROCESS_PARITY_EN
        par_d   = ^bus.message;
`endif
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
`ifdef MESSAGE_PROCESS_PARITY_EN
          state_d = PAR;
`else
          state_d = STOP;
`endif
        end else begin
          cnt_d   = cnt_q + 1'b1;
          shift_d = shift_q >> 1;
        end
      end
`ifdef MESSAGE_PROCESS_PARITY_EN
      PAR: if (tick) state_d = STOP;
`endif
      STOP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // line level for the upcoming cycle, so outputs stay registered
  always_comb begin
    data_d = IDLE_LEVEL;
    busy_d = (state_d != IDLE);
    unique case (state_d)
      START: data_d = START_LEVEL;
      DATA:  data_d = shift_d[0];
`ifdef MESSAGE_PROCESS_PARITY_EN
      PAR:   data_d = par_d;
`endif
      STOP:  data_d = STOP_LEVEL;
      default: data_d = IDLE_LEVEL;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      send_q  <= 1'b0;
      armed_q <= 1'b0;
      data_q  <= IDLE_LEVEL;
      busy_q  <= 1'b0;
`ifdef MESSAGE_PROCESS_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      send_q  <= bus.send;
      armed_q <= armed_q | ~bus.send;
      data_q  <= data_d;
      busy_q  <= busy_d;
`ifdef MESSAGE_PROCESS_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.data = data_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_message_process.sv
// Directed bench for message_process, MSG_W=5, CLK_DIV=4.
// Honors MESSAGE_PROCESS_PARITY_EN for the expected frame.
module tb_message_process;

  localparam int MSG_W   = 5;
  localparam int CLK_DIV = 4;
`ifdef MESSAGE_PROCESS_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = (MSG_W + 2 + PB) * CLK_DIV;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  message_process_if #(.MSG_W(MSG_W)) bus ();

  message_process #(
    .MSG_W   (MSG_W),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %b exp %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input logic [MSG_W-1:0] m, input int c);
    int b;
    b = c / CLK_DIV;
    if (b == 0) return 1'b0;
    if (b <= MSG_W) return m[b-1];
    if (PB == 1 && b == MSG_W + 1) return ^m;
    return 1'b1;
  endfunction

  // raise send; returns just after the edge that takes the request
  task automatic launch(input logic [MSG_W-1:0] m);
    @(posedge clk);
    #1;
    bus.send    = 1'b1;
    bus.message = m;
    @(posedge clk);
  endtask

  task automatic check_frame(input logic [MSG_W-1:0] m, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check("frame_data", bus.data, exp_bit(m, c));
      check("frame_busy", bus.busy, 1'b1);
    end
  endtask

  task automatic check_idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check("idle_data", bus.data, 1'b1);
      check("idle_busy", bus.busy, 1'b0);
    end
  endtask

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    rst         = 1'b0;
    bus.send    = 1'b1;
    bus.message = 5'b10101;

    // reset with send high, then release while still high
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_data", bus.data, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    rst = 1'b1;
    check_idle(6);
    bus.send = 1'b0;
    check_idle(2);

    // basic frame, send held about 5 cycles
    launch(5'b10101);
    fork
      check_frame(5'b10101, FL);
      begin
        repeat (4) @(negedge clk);
        bus.send = 1'b0;
      end
    join
    check_idle(3);

    // held send gives exactly one frame
    launch(5'b01101);
    check_frame(5'b01101, FL);
    check_idle(100 - FL);
    bus.send = 1'b0;
    check_idle(2);

    // request during data bits is dropped
    launch(5'b10110);
    fork
      check_frame(5'b10110, FL);
      begin
        repeat (CLK_DIV + 1) @(negedge clk);
        bus.send = 1'b0;
        repeat (CLK_DIV * 2) @(negedge clk);
        bus.send    = 1'b1;
        bus.message = 5'b00000;
        repeat (3) @(negedge clk);
        bus.send = 1'b0;
      end
    join
    check_idle(CLK_DIV * 3);

    // message changes after the start bit
    launch(5'b11111);
    fork
      check_frame(5'b11111, FL);
      begin
        repeat (CLK_DIV) @(negedge clk);
        bus.send    = 1'b0;
        bus.message = 5'b00000;
      end
    join
    check_idle(2);

    // reset during D2 aborts, then a fresh frame
    launch(5'b11011);
    fork
      check_frame(5'b11011, CLK_DIV * 3 + 2);
      begin
        repeat (2) @(negedge clk);
        bus.send = 1'b0;
      end
    join
    rst = 1'b0;
    #1;
    check("abort_data", bus.data, 1'b1);
    check("abort_busy", bus.busy, 1'b0);
    @(posedge clk);
    #1;
    check("abort_hold", bus.data, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    check_idle(2);
    launch(5'b01001);
    fork
      check_frame(5'b01001, FL);
      begin
        repeat (2) @(negedge clk);
        bus.send = 1'b0;
      end
    join
    check_idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
